// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_stall_ctrl
//  Purpose  : Pipeline hazard/stall controller beside the ID stage. Detects
//             load-use hazards (multi-cycle, LOAD_LAT), freezes the pipe on
//             data-memory wait, flushes on taken branch and keeps a
//             saturating count of load-use stall cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 0,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rn_id_i,
    input  logic [REG_AW-1:0] rm_id_i,
    input  logic              rn_valid_id_i,
    input  logic              rm_valid_id_i,
    input  logic [REG_AW-1:0] rd_ex_i,
    input  logic              memread_ex_i,
    input  logic              branch_taken_i,
    input  logic              mem_req_i,
    input  logic              mem_ready_i,
    input  logic              stat_clr_i,
    output logic              pc_stall_o,
    output logic              ifid_stall_o,
    output logic              id_bubble_o,
    output logic              ifid_flush_o,
    output logic              idex_flush_o,
    output logic              pipe_freeze_o,
    output logic [CNT_W-1:0]  stall_count_o
);

    // Down-counter only needs to hold LOAD_LAT-1.
    localparam int                CW       = (LOAD_LAT > 2) ? $clog2(LOAD_LAT) : 1;
    localparam logic [CW-1:0]     C_LAT_M1 = CW'(LOAD_LAT - 1);
    localparam logic [CW-1:0]     C_ONE    = CW'(1);
    localparam logic [REG_AW-1:0] C_ZERO   = REG_AW'(ZERO_REG);

    typedef enum logic [0:0] {
        ST_IDLE       = 1'b0,
        ST_LOAD_STALL = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_count_q;

    logic w_hazard;
    logic w_freeze;

    assign w_hazard = memread_ex_i && (rd_ex_i != C_ZERO) &&
                      ((rn_valid_id_i && (rn_id_i == rd_ex_i)) ||
                       (rm_valid_id_i && (rm_id_i == rd_ex_i)));
    assign w_freeze = mem_req_i && !mem_ready_i;

    // State and stall down-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and control outputs: freeze > branch > load-use stall.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_stall_o    = 1'b0;
        ifid_stall_o  = 1'b0;
        id_bubble_o   = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_flush_o  = 1'b0;
        pipe_freeze_o = 1'b0;
        if (!rst_n) begin
            // Outputs stay low while reset is held, whatever the inputs say.
        end else if (w_freeze) begin
            // Whole pipe holds; a pending branch is re-presented after the wait.
            pipe_freeze_o = 1'b1;
            pc_stall_o    = 1'b1;
            ifid_stall_o  = 1'b1;
        end else if (branch_taken_i) begin
            // The stalled instruction is squashed, so abandon any stall in progress.
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
            state_d      = ST_IDLE;
            cnt_d        = '0;
        end else if (state_q == ST_LOAD_STALL) begin
            pc_stall_o   = 1'b1;
            ifid_stall_o = 1'b1;
            id_bubble_o  = 1'b1;
            cnt_d        = cnt_q - C_ONE;
            if (cnt_q == C_ONE) begin
                state_d = ST_IDLE;
            end
        end else if (w_hazard) begin
            // First stall cycle is asserted with zero latency from detection.
            pc_stall_o   = 1'b1;
            ifid_stall_o = 1'b1;
            id_bubble_o  = 1'b1;
            if (LOAD_LAT > 1) begin
                state_d = ST_LOAD_STALL;
                cnt_d   = C_LAT_M1;
            end
        end
    end

    // Saturating stall-cycle counter; clear beats increment, both hold on freeze.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= '0;
        end else if (!w_freeze) begin
            if (stat_clr_i) begin
                stall_count_q <= '0;
            end else if (id_bubble_o && !(&stall_count_q)) begin
                stall_count_q <= stall_count_q + 1'b1;
            end
        end
    end

    assign stall_count_o = stall_count_q;

endmodule
`default_nettype wire
